// File: rtl/rush3d_pkg.sv
// Shared types and constants for the rush3d command path: dispatcher states,
// command channel indices and framebuffer write-state codes.
package rush3d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RUN  = 2'd2
  } disp_state_e;

  localparam int CMD_VALID_VERTICES  = 0;
  localparam int CMD_BACKGROUND_FILL = 1;
  localparam int CMD_PURGE           = 2;
  localparam int CMD_SWAP            = 3;

  typedef enum logic [1:0] {
    FB_WAIT       = 2'd0,
    FB_WRITE      = 2'd1,
    FB_PURGE      = 2'd2,
    FB_BACKGROUND = 2'd3
  } fb_state_e;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rush3d_cmd_dispatcher_if.sv
// CSR / engine handshake bundle between the host bridge (master) and the
// command dispatcher (slave).
interface rush3d_cmd_dispatcher_if
  import rush3d_pkg::*;
#(
  parameter int CSR_WIDTH = 64,
  parameter int NUM_CMDS  = 4
);
  localparam int IDX_W = idx_w(NUM_CMDS);

  logic [CSR_WIDTH-1:0] csr_in;
  logic [CSR_WIDTH-1:0] csr_out;
  logic                 csr_load;
  logic [NUM_CMDS-1:0]  cmd_flag;
  logic [NUM_CMDS-1:0]  cmd_done;
  logic                 clear_err;
  logic                 busy;
  logic [IDX_W-1:0]     active_cmd;
  logic                 timeout_err;
  logic [IDX_W-1:0]     timeout_id;

  modport master (
    output csr_in, cmd_done, clear_err,
    input  csr_out, csr_load, cmd_flag, busy, active_cmd, timeout_err, timeout_id
  );

  modport slave (
    input  csr_in, cmd_done, clear_err,
    output csr_out, csr_load, cmd_flag, busy, active_cmd, timeout_err, timeout_id
  );

endinterface

// File: rtl/rush3d_lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder.
module rush3d_lsb_priority_enc
  import rush3d_pkg::*;
#(
  parameter int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last to write idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/rush3d_cmd_dispatcher.sv
// Serialises CSR command bits into per-command engine flags, clears each bit
// via CSR writeback and waits for pulse/level completion under a watchdog.
module rush3d_cmd_dispatcher
  import rush3d_pkg::*;
#(
  parameter int                  CSR_WIDTH      = 64,
  parameter int                  NUM_CMDS       = 4,
  parameter int                  CMD_BASE       = 0,
  parameter logic [NUM_CMDS-1:0] PULSE_MASK     = NUM_CMDS'(1),
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input logic                    clock,
  input logic                    reset,
  rush3d_cmd_dispatcher_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_CMDS);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  disp_state_e          state_q, state_d;
  logic [IDX_W-1:0]     k_q, k_d;
  logic [NUM_CMDS-1:0]  flag_q, flag_d;
  logic                 load_q, load_d;
  logic [CSR_WIDTH-1:0] csr_out_q, csr_out_d;
  logic                 done_seen_q, done_seen_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     err_id_q, err_id_d;

  logic [NUM_CMDS-1:0]  pend;
  logic                 pend_vld;
  logic [IDX_W-1:0]     pend_idx;
  logic                 is_pulse, done_k, ack_now, cmpl, tmo;

  assign pend = bus.csr_in[CMD_BASE +: NUM_CMDS];

  rush3d_lsb_priority_enc #(.N(NUM_CMDS)) u_penc (
    .req   (pend),
    .valid (pend_vld),
    .idx   (pend_idx)
  );

  function automatic logic [CSR_WIDTH-1:0] bit_of(input logic [IDX_W-1:0] i);
    return CSR_WIDTH'(1) << (CMD_BASE + int'(i));
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    flag_d      = flag_q;
    load_d      = load_q;
    csr_out_d   = csr_out_q;
    done_seen_d = done_seen_q;
    wd_d        = wd_q;
    err_d       = err_q;
    err_id_d    = err_id_q;
    cmpl        = 1'b0;
    tmo         = 1'b0;
    is_pulse    = PULSE_MASK[k_q];
    done_k      = bus.cmd_done[k_q] & ~is_pulse;
    ack_now     = (bus.csr_in & bit_of(k_q)) == '0;

    unique case (state_q)
      IDLE: begin
        flag_d      = '0;
        load_d      = 1'b0;
        done_seen_d = 1'b0;
        wd_d        = '0;
        if (pend_vld) begin
          k_d       = pend_idx;
          flag_d    = NUM_CMDS'(1) << pend_idx;
          load_d    = 1'b1;
          csr_out_d = bus.csr_in & ~bit_of(pend_idx);
          state_d   = ACK;
        end
      end
      ACK: begin
        // Track host writes to the other CSR bits while the ack is pending.
        csr_out_d   = bus.csr_in & ~bit_of(k_q);
        done_seen_d = done_seen_q | done_k;
        if (is_pulse || done_seen_d) flag_d = '0;
        if (ack_now) begin
          load_d = 1'b0;
          if (is_pulse || done_seen_d) cmpl = 1'b1;
          else                         state_d = RUN;
        end
      end
      RUN: begin
        done_seen_d = done_seen_q | done_k;
        if (done_k) cmpl = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) wd_d = wd_q + 1'b1;

    if (cmpl) begin
      state_d     = IDLE;
      flag_d      = '0;
      load_d      = 1'b0;
      done_seen_d = 1'b0;
      wd_d        = '0;
    end else if (state_q != IDLE && TIMEOUT_CYCLES > 0 &&
                 wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      tmo         = 1'b1;
      state_d     = IDLE;
      flag_d      = '0;
      load_d      = 1'b0;
      done_seen_d = 1'b0;
      wd_d        = '0;
      err_id_d    = k_q;
    end

    // A fresh timeout beats a simultaneous clear.
    if (tmo)                 err_d = 1'b1;
    else if (bus.clear_err)  err_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      flag_q      <= '0;
      load_q      <= 1'b0;
      csr_out_q   <= '0;
      done_seen_q <= 1'b0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      flag_q      <= flag_d;
      load_q      <= load_d;
      csr_out_q   <= csr_out_d;
      done_seen_q <= done_seen_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
    end
  end

  assign bus.csr_out     = csr_out_q;
  assign bus.csr_load    = load_q;
  assign bus.cmd_flag    = flag_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.active_cmd  = k_q;
  assign bus.timeout_err = err_q;
  assign bus.timeout_id  = err_id_q;

endmodule

// File: tb/tb_rush3d_cmd_dispatcher.sv
// Directed scenarios plus randomized host/engine traffic, checked every cycle
// against a transaction-level model of the dispatcher.
module tb_rush3d_cmd_dispatcher;

  localparam int NC = 4;
  localparam int CB = 0;
  localparam logic [NC-1:0] PM = 4'b0001;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rush3d_cmd_dispatcher_if #(.CSR_WIDTH(64), .NUM_CMDS(NC)) bus ();

  rush3d_cmd_dispatcher #(
    .CSR_WIDTH(64), .NUM_CMDS(NC), .CMD_BASE(CB),
    .PULSE_MASK(PM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a command in service is finished once the host has acknowledged
  // (bit read back as 0) and either it is pulse-mode or its done was seen.
  int          m_cur = -1;
  int          m_age;
  bit          m_acked, m_done;
  logic [3:0]  m_flag = '0;
  logic        m_load = 1'b0;
  logic [63:0] m_out = '0;
  logic        m_err = 1'b0;
  int          m_eid = 0;
  bit          m_pulse, m_fin;

  always @(posedge clock) begin
    if (reset) begin
      m_cur = -1; m_flag = '0; m_load = 1'b0; m_out = '0; m_err = 1'b0; m_eid = 0;
    end else if (m_cur < 0) begin
      m_flag = '0; m_load = 1'b0;
      for (int i = 0; i < NC; i++)
        if (bus.csr_in[CB+i]) begin m_cur = i; break; end
      if (m_cur >= 0) begin
        m_flag = 4'(1 << m_cur); m_load = 1'b1;
        m_out = bus.csr_in & ~(64'd1 << (CB + m_cur));
        m_age = 0; m_acked = 0; m_done = 0;
      end
      if (bus.clear_err) m_err = 1'b0;
    end else begin
      m_pulse = PM[m_cur];
      if (!m_acked) begin
        m_out = bus.csr_in & ~(64'd1 << (CB + m_cur));
        if (!bus.csr_in[CB+m_cur]) m_acked = 1;
      end
      if (!m_pulse && bus.cmd_done[m_cur]) m_done = 1;
      m_fin  = m_acked && (m_pulse || m_done);
      m_load = !m_acked;
      m_flag = (m_pulse || m_done) ? 4'd0 : 4'(1 << m_cur);
      if (m_fin) begin
        m_cur = -1; m_flag = '0; m_load = 1'b0;
        if (bus.clear_err) m_err = 1'b0;
      end else if (m_age == TO - 1) begin
        m_err = 1'b1; m_eid = m_cur; m_cur = -1; m_flag = '0; m_load = 1'b0;
      end else begin
        m_age++;
        if (bus.clear_err) m_err = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    chk("m_busy", bus.busy, m_cur >= 0);
    chk("m_flag", bus.cmd_flag, m_flag);
    chk("m_load", bus.csr_load, m_load);
    chk("m_err", bus.timeout_err, m_err);
    chk("m_eid", bus.timeout_id, m_eid);
    if (m_load) chk("m_out", bus.csr_out, m_out);
    if (m_cur >= 0) chk("m_act", bus.active_cmd, m_cur);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  logic [63:0] csr, rnd;

  initial begin
    reset = 1'b1; bus.csr_in = '0; bus.cmd_done = '0; bus.clear_err = 1'b0;
    tick(); tick();
    chk("rst_flag", bus.cmd_flag, 0); chk("rst_load", bus.csr_load, 0);
    chk("rst_out", bus.csr_out, 0);   chk("rst_busy", bus.busy, 0);
    chk("rst_act", bus.active_cmd, 0); chk("rst_err", bus.timeout_err, 0);
    reset = 1'b0;

    // 1: pulse command
    bus.csr_in = 64'h1; tick();
    chk("t1_flag", bus.cmd_flag, 4'b0001); chk("t1_load", bus.csr_load, 1);
    chk("t1_out", bus.csr_out, 64'h0);
    tick();
    chk("t1_flag_drop", bus.cmd_flag, 0); chk("t1_load_hold", bus.csr_load, 1);
    bus.csr_in = 64'h0; tick();
    chk("t1_load_drop", bus.csr_load, 0); chk("t1_idle", bus.busy, 0);

    // 2: level command, late done
    bus.csr_in = 64'h2; tick();
    chk("t2_flag", bus.cmd_flag, 4'b0010);
    tick(); bus.csr_in = 64'h0; tick();
    chk("t2_run_flag", bus.cmd_flag, 4'b0010); chk("t2_run_busy", bus.busy, 1);
    chk("t2_run_load", bus.csr_load, 0);
    repeat (4) tick();
    chk("t2_hold", bus.cmd_flag, 4'b0010);
    bus.cmd_done = 4'b0010; tick(); bus.cmd_done = '0;
    chk("t2_done_flag", bus.cmd_flag, 0); chk("t2_done_busy", bus.busy, 0);

    // 3: early done in ACK
    bus.csr_in = 64'h4; tick();
    chk("t3_flag", bus.cmd_flag, 4'b0100);
    bus.cmd_done = 4'b0100; tick(); bus.cmd_done = '0;
    chk("t3_busy", bus.busy, 1); chk("t3_load", bus.csr_load, 1);
    tick(); tick(); bus.csr_in = 64'h0; tick();
    chk("t3_idle", bus.busy, 0); chk("t3_load_drop", bus.csr_load, 0);

    // 4: priority and upper-bit preservation
    bus.csr_in = 64'hF_0000_000C; tick();
    chk("t4_act2", bus.active_cmd, 2); chk("t4_out2", bus.csr_out, 64'hF_0000_0008);
    chk("t4_flag2", bus.cmd_flag, 4'b0100);
    bus.csr_in = 64'hF_0000_0008; tick();
    chk("t4_load2", bus.csr_load, 0);
    bus.cmd_done = 4'b0100; tick(); bus.cmd_done = '0;
    chk("t4_idle2", bus.busy, 0);
    tick();
    chk("t4_act3", bus.active_cmd, 3); chk("t4_out3", bus.csr_out, 64'hF_0000_0000);
    chk("t4_flag3", bus.cmd_flag, 4'b1000);
    bus.csr_in = 64'hF_0000_0000; tick();
    bus.cmd_done = 4'b1000; tick(); bus.cmd_done = '0;
    chk("t4_idle3", bus.busy, 0);

    // 5: watchdog
    bus.csr_in = 64'h8; tick(); bus.csr_in = 64'h0; tick();
    repeat (14) tick();
    chk("t5_busy15", bus.busy, 1); chk("t5_noerr", bus.timeout_err, 0);
    tick();
    chk("t5_busy", bus.busy, 0); chk("t5_err", bus.timeout_err, 1);
    chk("t5_id", bus.timeout_id, 3); chk("t5_flag", bus.cmd_flag, 0);
    bus.clear_err = 1'b1; tick(); bus.clear_err = 1'b0;
    chk("t5_clr", bus.timeout_err, 0);

    // 6: reset mid-RUN
    bus.csr_in = 64'h2; tick(); bus.csr_in = 64'h0; tick();
    chk("t6_run", bus.cmd_flag, 4'b0010);
    reset = 1'b1; tick();
    chk("t6_flag", bus.cmd_flag, 0); chk("t6_busy", bus.busy, 0);
    chk("t6_load", bus.csr_load, 0); chk("t6_out", bus.csr_out, 0);
    chk("t6_act", bus.active_cmd, 0);
    reset = 1'b0; tick(); tick();
    chk("t6_quiet", bus.cmd_flag, 0); chk("t6_quiet_busy", bus.busy, 0);

    // Random host / engine traffic
    csr = '0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (m_cur >= 0 && m_load && $urandom_range(0, 2) == 0) csr[CB+m_cur] = 1'b0;
      if ($urandom_range(0, 7) == 0) csr[CB + $urandom_range(0, NC-1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        rnd = {$urandom(), $urandom()};
        csr[63:4] = rnd[63:4];
      end
      bus.csr_in    = csr;
      bus.cmd_done  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      bus.clear_err = ($urandom_range(0, 19) == 0);
      tick();
    end
    reset = 1'b0; bus.cmd_done = '0; bus.clear_err = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rush3d_cmd_dispatcher.md
Name: rush3d_cmd_dispatcher

Overview:
Parametrised successor to the single-purpose rush3d control/status sequencer. It watches NUM_CMDS command bits in the host control/status register (CSR) and dispatches them one at a time, lowest index first. For each command it raises a per-command flag, writes the CSR back with that command bit cleared, and waits for the engine to complete in either pulse or level mode. A watchdog aborts any command that stalls. It sits between the Avalon CSR bridge and the rasteriser/framebuffer engines.

Parameters:
CSR_WIDTH, 64, width of the CSR data path.
NUM_CMDS, 4, number of command bits/channels (1..16).
CMD_BASE, 0, CSR bit position of command 0; command i is at bit CMD_BASE+i. CMD_BASE+NUM_CMDS must be ≤ CSR_WIDTH.
PULSE_MASK, 4'b0001, bit i=1 means command i is pulse mode (flag lasts 1 cycle, no done handshake). Bit i=0 means level mode (flag held until cmd_done[i]).
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog.

Ports:
clock  in  1  system clock.
reset  in  1  reset; one clock, reset is synchronous and active-high.
csr_in  in  CSR_WIDTH  current CSR contents.
csr_out  out  CSR_WIDTH  CSR writeback value.
csr_load  out  1  CSR writeback strobe, level.
cmd_flag  out  NUM_CMDS  per-command start/active flag.
cmd_done  in  NUM_CMDS  per-command completion, sampled only for the active level-mode command.
clear_err  in  1  one-cycle clear of timeout_err.
busy  out  1  high whenever state != IDLE.
active_cmd  out  max(1,$clog2(NUM_CMDS))  index of the command in service.
timeout_err  out  1  sticky watchdog error.
timeout_id  out  max(1,$clog2(NUM_CMDS))  index of the command that timed out.

Behaviour:
- Reset (synchronous, takes effect on the next edge): every output is 0, state=IDLE, done_seen=0, watchdog=0. Reset mid-command aborts it; the CSR bit is not cleared.
- States: IDLE, ACK, RUN.
- IDLE: pend = csr_in[CMD_BASE +: NUM_CMDS]. If pend != 0, select k = lowest set index. On the next edge:
  - cmd_flag[k]=1, csr_load=1, csr_out = csr_in & ~(1<<(CMD_BASE+k)), active_cmd=k, busy=1.
  - Go to ACK.
  - Latency: bit visible at edge n gives flag/load high after edge n+1.
- ACK:
  - Each cycle, csr_out is re-registered as csr_in with bit CMD_BASE+k cleared, so host writes to other bits are preserved with a 1-cycle lag.
  - csr_load stays high until csr_in bit CMD_BASE+k reads 0. On that edge csr_load goes to 0.
  - Pulse-mode k: cmd_flag[k] drops one cycle after it rose, regardless of state.
  - Level-mode k: cmd_done[k] is latched into done_seen in any non-IDLE state.
  - On the same edge that csr_load drops: return to IDLE if pulse mode or done_seen. Otherwise go to RUN.
- RUN (level mode only): cmd_flag[k] held high. When cmd_done[k]=1: cmd_flag[k]=0 and go to IDLE on that edge.
- Leaving to IDLE: busy=0, done_seen=0, watchdog=0. A new dispatch may be evaluated on the very next edge.
- Only one cmd_flag bit is ever high at a time. cmd_done[j] for j≠k, and any cmd_done seen in IDLE, are ignored.
- Simultaneous pending bits are served strictly in ascending index order, one per dispatch. Bits set by the host during service wait for IDLE.
- Watchdog (TIMEOUT_CYCLES>0): counts every non-IDLE cycle. When count reaches TIMEOUT_CYCLES-1 and the command would not otherwise complete that edge, then on that edge:
  - cmd_flag=0, csr_load=0.
  - timeout_err=1, timeout_id=k.
  - Go to IDLE.
  - The CSR bit is left as is; it retriggers only if still set.
- timeout_err: cleared by clear_err=1 or reset. If clear_err and a new timeout occur on the same edge, the set wins.

Decomposition:
- Package rush3d_pkg holds:
  - state enum (IDLE=2'd0, ACK=2'd1, RUN=2'd2).
  - command index constants CMD_VALID_VERTICES=0, CMD_BACKGROUND_FILL=1, CMD_PURGE=2, CMD_SWAP=3.
  - framebuffer write-state codes (WAIT=0, WRITE=1, PURGE=2, BACKGROUND=3).
- Sub-module rush3d_lsb_priority_enc #(N): input req[N]; outputs valid, idx (lowest set bit). It is purely combinational and reused by later arbiters.

Test Plan:
(Bench parameters: NUM_CMDS=4, CMD_BASE=0, PULSE_MASK=4'b0001, TIMEOUT_CYCLES=16.)
1. Pulse command: csr_in=64'h1 at edge 0 -> edge 1: cmd_flag=4'b0001, csr_load=1, csr_out=0. Edge 2: cmd_flag=0. Host clears bit at edge 3 -> csr_load=0, busy=0 at edge 4.
2. Level command with late done: csr_in=64'h2, bit cleared 2 cycles after load, cmd_done[1] pulsed 5 cycles later -> state ACK->RUN; cmd_flag[1] high until the done edge; then busy=0.
3. Early done during ACK: csr_in=64'h4, cmd_done[2] pulsed the first cycle in ACK, bit cleared 3 cycles later -> returns directly to IDLE on the load-drop edge; RUN is never entered.
4. Priority and preservation: csr_in=64'hF0000_000C -> cmd 2 served first, csr_out=64'hF0000_0008. Then cmd 3, csr_out=64'hF0000_0000. Upper bits are never altered.
5. Timeout: csr_in=64'h8, bit cleared, cmd_done never asserted -> after 16 busy cycles timeout_err=1, timeout_id=3, cmd_flag=0, busy=0. clear_err pulse -> timeout_err=0.
6. Reset mid-RUN: assert reset during cmd 1 RUN -> next edge all outputs 0; with csr_in=0 no flag rises after reset deasserts.
